// File: rtl/seq_64_bit_subtractor_pkg.sv
// Shared types and sizing for the sequential borrow-chain subtractor.
package sub_pkg;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } state_t;

  localparam int unsigned W_DEFAULT     = 64;
  localparam int unsigned CHUNK_DEFAULT = 16;

  // A single-slice configuration still needs a 1-bit counter.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  localparam int unsigned NUM_CHUNKS = W_DEFAULT / CHUNK_DEFAULT;
  localparam int unsigned IDX_W      = idx_width(NUM_CHUNKS);

endpackage

// File: rtl/seq_64_bit_subtractor_borrow_slice.sv
// One CHUNK-bit slice of the borrow chain: {bout, d} = x - y - bin.
module borrow_slice_subtractor #(
  parameter int unsigned CHUNK = 16
) (
  input  logic [CHUNK-1:0] x,
  input  logic [CHUNK-1:0] y,
  input  logic             bin,
  output logic [CHUNK-1:0] d,
  output logic             bout
);

  logic [CHUNK:0] r;

  // The extra top bit becomes 1 exactly when the slice result goes negative.
  always_comb r = {1'b0, x} - {1'b0, y} - {{CHUNK{1'b0}}, bin};

  assign d    = r[CHUNK-1:0];
  assign bout = r[CHUNK];

endmodule

// File: rtl/seq_64_bit_subtractor.sv
// Multi-cycle W-bit subtractor walking a borrow chain one CHUNK slice per clock.
module seq_64_bit_subtractor
  import sub_pkg::*;
#(
  parameter int unsigned W     = 64,
  parameter int unsigned CHUNK = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] diff,
  output logic         borrow,
  output logic         ovf
);

  localparam int unsigned NCHUNK = W / CHUNK;
  localparam int unsigned IW     = idx_width(NCHUNK);

  state_t          state_q, state_d;
  logic [W-1:0]    a_q, a_d;
  logic [W-1:0]    b_q, b_d;
  logic [W-1:0]    work_q, work_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic            bw_q, bw_d;
  logic [W-1:0]    diff_q, diff_d;
  logic            borrow_q, borrow_d;
  logic            ovf_q, ovf_d;

  logic [CHUNK-1:0] x_sl, y_sl, d_sl;
  logic             bout_sl;
  logic [W-1:0]     a_sh, b_sh, work_next, slice_mask;
  int unsigned      sh;
  logic             last;

  // Slice selection by shifting keeps the mux valid for CHUNK == W as well.
  always_comb begin
    sh         = int'(idx_q) * CHUNK;
    a_sh       = a_q >> sh;
    b_sh       = b_q >> sh;
    x_sl       = a_sh[CHUNK-1:0];
    y_sl       = b_sh[CHUNK-1:0];
    slice_mask = W'({CHUNK{1'b1}}) << sh;
    work_next  = (work_q & ~slice_mask) | (W'(d_sl) << sh);
    last       = (idx_q == IW'(NCHUNK - 1));
  end

  borrow_slice_subtractor #(
    .CHUNK(CHUNK)
  ) u_slice (
    .x   (x_sl),
    .y   (y_sl),
    .bin (bw_q),
    .d   (d_sl),
    .bout(bout_sl)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      work_q   <= '0;
      idx_q    <= '0;
      bw_q     <= 1'b0;
      diff_q   <= '0;
      borrow_q <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      work_q   <= work_d;
      idx_q    <= idx_d;
      bw_q     <= bw_d;
      diff_q   <= diff_d;
      borrow_q <= borrow_d;
      ovf_q    <= ovf_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    work_d   = work_q;
    idx_d    = idx_q;
    bw_d     = bw_q;
    diff_d   = diff_q;
    borrow_d = borrow_q;
    ovf_d    = ovf_q;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          a_d     = a;
          b_d     = b;
          work_d  = '0;
          idx_d   = '0;
          bw_d    = 1'b0;
          state_d = CALC;
        end else begin
          state_d = IDLE;
        end
      end
      CALC: begin
        work_d = work_next;
        bw_d   = bout_sl;
        idx_d  = idx_q + 1'b1;
        if (last) begin
          diff_d   = work_next;
          borrow_d = bout_sl;
          ovf_d    = (a_q[W-1] != b_q[W-1]) && (work_next[W-1] != a_q[W-1]);
          idx_d    = '0;
          state_d  = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy   = (state_q == CALC);
  assign done   = (state_q == DONE);
  assign diff   = diff_q;
  assign borrow = borrow_q;
  assign ovf    = ovf_q;

endmodule

// File: tb/tb_seq_64_bit_subtractor.sv
// Bench for seq_64_bit_subtractor: 4-slice and single-slice instances vs. 65-bit reference.
module tb_seq_64_bit_subtractor;

  logic        clk = 1'b0;
  logic        rst = 1'b1;

  logic        start_a = 1'b0;
  logic [63:0] a_a = '0, b_a = '0;
  logic        busy_a, done_a, borrow_a, ovf_a;
  logic [63:0] diff_a;

  logic        start_w = 1'b0;
  logic [63:0] a_w = '0, b_w = '0;
  logic        busy_w, done_w, borrow_w, ovf_w;
  logic [63:0] diff_w;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  seq_64_bit_subtractor dut_a (
    .clk(clk), .rst(rst), .start(start_a), .a(a_a), .b(b_a),
    .busy(busy_a), .done(done_a), .diff(diff_a), .borrow(borrow_a), .ovf(ovf_a)
  );

  seq_64_bit_subtractor #(.W(64), .CHUNK(64)) dut_w (
    .clk(clk), .rst(rst), .start(start_w), .a(a_w), .b(b_w),
    .busy(busy_w), .done(done_w), .diff(diff_w), .borrow(borrow_w), .ovf(ovf_w)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: widen to 65 bits; unsigned borrow from the top bit, signed overflow
  // from the sign-extended result not fitting in 64 bits.
  task automatic ref_sub(input logic [63:0] x, input logic [63:0] y,
                         output logic [63:0] d, output logic br, output logic ov);
    logic [64:0] u, s;
    u  = {1'b0, x} - {1'b0, y};
    s  = {x[63], x} - {y[63], y};
    d  = u[63:0];
    br = u[64];
    ov = (s[64] != s[63]);
  endtask

  task automatic run_a(input logic [63:0] x, input logic [63:0] y,
                       output int cyc, output int bcnt);
    start_a = 1'b1; a_a = x; b_a = y;
    @(posedge clk); #1;
    start_a = 1'b0;
    cyc = 0; bcnt = 0;
    while (!done_a && cyc < 40) begin
      if (busy_a) bcnt++;
      @(posedge clk); #1;
      cyc++;
    end
  endtask

  task automatic run_w(input logic [63:0] x, input logic [63:0] y,
                       output int cyc, output int bcnt);
    start_w = 1'b1; a_w = x; b_w = y;
    @(posedge clk); #1;
    start_w = 1'b0;
    cyc = 0; bcnt = 0;
    while (!done_w && cyc < 40) begin
      if (busy_w) bcnt++;
      @(posedge clk); #1;
      cyc++;
    end
  endtask

  task automatic check_a(input string tag, input logic [63:0] x, input logic [63:0] y);
    logic [63:0] d;
    logic br, ov;
    ref_sub(x, y, d, br, ov);
    chk({tag, "_diff"}, diff_a, d);
    chk({tag, "_borrow"}, 64'(borrow_a), 64'(br));
    chk({tag, "_ovf"}, 64'(ovf_a), 64'(ov));
  endtask

  task automatic check_w(input string tag, input logic [63:0] x, input logic [63:0] y);
    logic [63:0] d;
    logic br, ov;
    ref_sub(x, y, d, br, ov);
    chk({tag, "_diff"}, diff_w, d);
    chk({tag, "_borrow"}, 64'(borrow_w), 64'(br));
    chk({tag, "_ovf"}, 64'(ovf_w), 64'(ov));
  endtask

  function automatic logic [63:0] rnd64(input int mode);
    logic [63:0] v;
    v = {$urandom, $urandom};
    case (mode)
      1: v = 64'($urandom_range(0, 3));
      2: v = {v[63], {47{v[62]}}, v[15:0]};
      default: ;
    endcase
    return v;
  endfunction

  initial begin
    int cyc, bcnt, dn;
    logic [63:0] x, y;

    // Reset state
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    chk("rst_busy", 64'(busy_a), 64'd0);
    chk("rst_done", 64'(done_a), 64'd0);
    chk("rst_diff", diff_a, 64'd0);
    chk("rst_borrow", 64'(borrow_a), 64'd0);
    chk("rst_ovf", 64'(ovf_a), 64'd0);
    @(posedge clk); #1;

    // Basic op with latency and busy width
    run_a(64'd10, 64'd3, cyc, bcnt);
    chk("lat_10_3", 64'(cyc), 64'd4);
    chk("busy_cnt_10_3", 64'(bcnt), 64'd4);
    chk("busy_at_done", 64'(busy_a), 64'd0);
    check_a("10_3", 64'd10, 64'd3);
    chk("10_3_diff_const", diff_a, 64'd7);
    @(posedge clk); #1;
    chk("done_pulse_one", 64'(done_a), 64'd0);
    chk("hold_idle_diff", diff_a, 64'd7);

    // Wrap-around: borrow ripples through every slice
    run_a(64'd0, 64'd1, cyc, bcnt);
    chk("wrap_diff", diff_a, 64'hFFFF_FFFF_FFFF_FFFF);
    chk("wrap_borrow", 64'(borrow_a), 64'd1);
    chk("wrap_ovf", 64'(ovf_a), 64'd0);

    run_a(64'h8000_0000_0000_0000, 64'd1, cyc, bcnt);
    chk("min_diff", diff_a, 64'h7FFF_FFFF_FFFF_FFFF);
    chk("min_borrow", 64'(borrow_a), 64'd0);
    chk("min_ovf", 64'(ovf_a), 64'd1);

    run_a(64'h0001_0000_0000_0000, 64'h0000_FFFF_FFFF_FFFF, cyc, bcnt);
    chk("chain_diff", diff_a, 64'd1);
    chk("chain_borrow", 64'(borrow_a), 64'd0);

    // start/operand changes during CALC ignored; start held in DONE chains a second op
    start_a = 1'b1; a_a = 64'd500; b_a = 64'd123;
    @(posedge clk); #1;
    start_a = 1'b0; a_a = 64'h1234; b_a = 64'h0FFF_0000_0000_0000;
    cyc = 0;
    while (!done_a && cyc < 40) begin
      if (cyc == 2) start_a = 1'b1;
      @(posedge clk); #1;
      cyc++;
    end
    chk("ign_lat", 64'(cyc), 64'd4);
    check_a("ign", 64'd500, 64'd123);
    @(posedge clk); #1;
    start_a = 1'b0;
    cyc = 1;
    while (!done_a && cyc < 40) begin
      @(posedge clk); #1;
      cyc++;
    end
    chk("b2b_gap", 64'(cyc), 64'd5);
    check_a("b2b", 64'h1234, 64'h0FFF_0000_0000_0000);
    @(posedge clk); #1;

    // Reset on the second CALC cycle aborts the op
    start_a = 1'b1; a_a = 64'd77; b_a = 64'd99;
    @(posedge clk); #1;
    start_a = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("abort_busy", 64'(busy_a), 64'd0);
    chk("abort_done", 64'(done_a), 64'd0);
    chk("abort_diff", diff_a, 64'd0);
    chk("abort_borrow", 64'(borrow_a), 64'd0);
    dn = 0;
    repeat (6) begin
      @(posedge clk); #1;
      if (done_a) dn++;
    end
    chk("abort_no_done", 64'(dn), 64'd0);
    run_a(64'd77, 64'd99, cyc, bcnt);
    check_a("after_abort", 64'd77, 64'd99);

    // Single-slice instance
    run_w(64'd10, 64'd3, cyc, bcnt);
    chk("w_lat", 64'(cyc), 64'd1);
    chk("w_busy_cnt", 64'(bcnt), 64'd1);
    check_w("w_10_3", 64'd10, 64'd3);
    run_w(64'd0, 64'd1, cyc, bcnt);
    check_w("w_wrap", 64'd0, 64'd1);

    // Random regression on both configurations
    for (int i = 0; i < 1000; i++) begin
      x = rnd64(int'($urandom_range(0, 3)));
      y = ($urandom_range(0, 9) == 0) ? x : rnd64(int'($urandom_range(0, 3)));
      run_a(x, y, cyc, bcnt);
      chk("rnd_lat", 64'(cyc), 64'd4);
      check_a("rnd", x, y);
      run_w(x, y, cyc, bcnt);
      chk("rnd_w_lat", 64'(cyc), 64'd1);
      check_w("rnd_w", x, y);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/seq_64_bit_subtractor.md
Name: seq_64_bit_subtractor

Overview:
Multi-cycle 64-bit unsigned/two's-complement subtractor, the inverse-direction companion to the registered 64-bit adder datapath. It computes diff = a - b by walking a borrow chain across CHUNK-bit slices, one slice per clock. It uses a start/busy/done handshake and holds results until the next operation. It sits beside the adder in the arithmetic test datapath, so security/fault experiments can exercise a sequential borrow chain.

Parameters:
W, 64, operand/result width in bits; must be a multiple of CHUNK
CHUNK, 16, slice width processed per cycle; CHUNK = W gives a single compute cycle

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous, active-high reset
start  input  1  request a new subtraction; sampled only when the block accepts (IDLE or DONE)
a  input  W  minuend; captured on the accepting edge
b  input  W  subtrahend; captured on the accepting edge
busy  output  1  high while computing (CALC state)
done  output  1  one-cycle pulse; results valid from this cycle on
diff  output  W  registered a - b mod 2^W
borrow  output  1  registered; 1 iff a < b (unsigned)
ovf  output  1  registered signed overflow: (a[W-1] != b[W-1]) && (diff[W-1] != a[W-1])

Behaviour:
- Interface: one clock, clk; reset is synchronous and active-high, named rst.
- Reset: state=IDLE; busy=0, done=0, diff=0, borrow=0, ovf=0; internal operand/work regs, slice counter and borrow bit cleared.
- Reset mid-operation aborts the subtraction. No done pulse follows and outputs read 0.
- States:
  - IDLE: on start=1, capture a,b into a_reg,b_reg; idx=0, bw=0; go to CALC.
  - CALC: busy=1. Each edge computes slice idx: {bw_next, work[idx]} = a_reg[idx] - b_reg[idx] - bw. Then idx++ and bw=bw_next.
  - CALC exit: on the edge processing slice NUM_CHUNKS-1, load diff from the completed work word, borrow=bw_next, ovf per formula; set done=1; go to DONE.
  - DONE: done=1 for exactly this cycle, busy=0. With start=1 it behaves like IDLE (accept, go to CALC). Otherwise go to IDLE.
- Latency: start accepted at edge E; done high in the cycle after edge E+NUM_CHUNKS (E+4 with defaults). Back-to-back throughput is one result per NUM_CHUNKS+1 cycles.
- start while in CALC is ignored. a/b changes after the accepting edge have no effect.
- diff/borrow/ovf change only on the completion edge (or reset) and otherwise hold, including across IDLE.
- Wrap-around: 0 - 1 gives all-ones with borrow=1. Width arithmetic is mod 2^W; no sign extension.
- NUM_CHUNKS = W/CHUNK. The counter width is clog2(NUM_CHUNKS), minimum 1.

Decomposition:
- Package sub_pkg:
  - state enum {IDLE, CALC, DONE}
  - localparam NUM_CHUNKS
  - IDX_W
- One natural sub-module: borrow_slice_subtractor. It is combinational, CHUNK-bit: inputs x, y, bin; outputs d, bout. One instance is driven by slice muxes indexed by idx.

Test Plan:
- Reset, then start with a=64'd10, b=64'd3 -> done exactly 4 cycles after the accept edge; diff=7, borrow=0, ovf=0; busy high for exactly 4 cycles.
- a=0, b=1 -> diff=64'hFFFF_FFFF_FFFF_FFFF, borrow=1, ovf=0 (borrow ripples through all 4 slices).
- a=64'h8000_0000_0000_0000, b=1 -> diff=64'h7FFF_FFFF_FFFF_FFFF, borrow=0, ovf=1. Also a=64'h0001_0000_0000_0000, b=64'h0000_FFFF_FFFF_FFFF -> diff=1, borrow=0 (cross-slice borrow chain).
- start pulsed and a/b changed during CALC -> no restart; the result matches the originally captured operands. start held high in the DONE cycle -> next op accepted, second done 5 cycles after the first.
- rst asserted on the 2nd CALC cycle -> no done pulse; the next cycle shows busy=0, diff=0, borrow=0; a fresh op afterwards computes correctly.
- Random regression with 1000 ops: results match a 65-bit reference {borrow,diff} = {1'b0,a} - {1'b0,b}. Repeat with CHUNK=64 (single-cycle compute, done 1 cycle after accept).
